// File: rtl/lsu_ctrl_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Holds funct3 codes, FSM states, access-size decode and alignment checks.
package lsu_ctrl_pkg;

    localparam int LSU_TIMEOUT = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    // Any funct3 that is not a defined byte/half access falls back to a word access.
    function automatic lsu_size_e lsu_size(input logic wen, input logic [2:0] funct3);
        lsu_size_e sz;
        sz = SZ_W;
        if (wen) begin
            if (funct3 == F3_SB)      sz = SZ_B;
            else if (funct3 == F3_SH) sz = SZ_H;
        end else begin
            if (funct3 == F3_LB || funct3 == F3_LBU)      sz = SZ_B;
            else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_H;
        end
        return sz;
    endfunction

    function automatic logic lsu_unsigned(input logic wen, input logic [2:0] funct3);
        return !wen && (funct3 == F3_LBU || funct3 == F3_LHU);
    endfunction

    function automatic logic lsu_misaligned(input logic wen, input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        lsu_size_e sz;
        sz = lsu_size(wen, funct3);
        return (sz == SZ_H && addr_lo[0]) || (sz == SZ_W && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store mask/replication and load extraction
// with sign or zero extension. Misaligned H/W offsets are truncated to natural alignment.
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            wen,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wmask,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata_ext
);

    lsu_size_e         size;
    logic              uns;
    logic [1:0]        off;
    logic [XLEN-1:0]   lane;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        size       = lsu_size(wen, funct3);
        uns        = lsu_unsigned(wen, funct3);
        off        = 2'd0;
        wmask      = 4'b1111;
        wdata_lane = wdata;
        case (size)
            SZ_B: begin
                off        = addr_lo;
                wmask      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SZ_H: begin
                off        = {addr_lo[1], 1'b0};
                wmask      = 4'b0011 << off;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase

        // Bring the addressed lane down to bit 0, then extend to full width.
        lane      = rdata >> {off, 3'b000};
        byte_s    = lane[7:0];
        half_s    = lane[15:0];
        rdata_ext = lane;
        case (size)
            SZ_B:    rdata_ext = uns ? XLEN'(lane[7:0])  : XLEN'(byte_s);
            SZ_H:    rdata_ext = uns ? XLEN'(lane[15:0]) : XLEN'(half_s);
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: valid/ready request to a variable-latency memory port with a read timeout.
// Optional MISALIGN_TRAP_EN: misaligned H/W requests answer immediately with resp_err, memory untouched.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = LSU_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e      state, state_nxt;
    logic            r_wen;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [CNT_W-1:0] cnt;
    logic [3:0]      a_wmask;
    logic [XLEN-1:0] a_wdata;
    logic [XLEN-1:0] a_rdata;
    logic            trap;
    logic            timeout;

    lsu_align #(.XLEN(XLEN)) u_align (
        .wen        (r_wen),
        .funct3     (r_funct3),
        .addr_lo    (r_addr[1:0]),
        .wdata      (r_wdata),
        .rdata      (mem_rdata),
        .wmask      (a_wmask),
        .wdata_lane (a_wdata),
        .rdata_ext  (a_rdata)
    );

`ifdef MISALIGN_TRAP_EN
    assign trap = lsu_misaligned(req_wen, req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = 4'b0000;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = trap ? S_RESP : S_REQ;
            end
            S_REQ: begin
                mem_valid = 1'b1;
                mem_wen   = r_wen;
                mem_addr  = {r_addr[XLEN-1:2], 2'b00};
                if (r_wen) begin
                    mem_wdata = a_wdata;
                    mem_wmask = a_wmask;
                end
                if (mem_ready) state_nxt = r_wen ? S_RESP : S_WAIT_R;
            end
            S_WAIT_R: begin
                if (mem_rvalid || timeout) state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Response fields are preset at accept (store / trap outcome) and overwritten by the read phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen      <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wen      <= req_wen;
                        r_funct3   <= req_funct3;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= trap;
                    end
                end
                S_REQ: begin
                    if (mem_ready) cnt <= '0;
                end
                S_WAIT_R: begin
                    if (mem_rvalid) begin
                        resp_rdata <= a_rdata;
                        resp_err   <= 1'b0;
                    end else if (timeout) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
